// File: rtl/decode_stage_pkg.sv
// Shared trit encodings, opcode map and default field sizes
// for the balanced-ternary decode stage.
package decode_stage_pkg;

  localparam int WORD_SIZE_DEF      = 9;
  localparam int OPCODE_SIZE_DEF    = 3;
  localparam int REG_ADDR_SIZE_DEF  = 2;
  localparam int SMALL_IMM_SIZE_DEF = 2;

  localparam logic [1:0] TRIT_Z = 2'b00;
  localparam logic [1:0] TRIT_P = 2'b01;
  localparam logic [1:0] TRIT_N = 2'b10;
  localparam logic [1:0] TRIT_X = 2'b11;

  // Opcodes are three trits, most significant first
  localparam logic [5:0] OP_NOP   = {TRIT_Z, TRIT_Z, TRIT_Z};
  localparam logic [5:0] OP_NOT   = {TRIT_Z, TRIT_Z, TRIT_P};
  localparam logic [5:0] OP_AND   = {TRIT_Z, TRIT_Z, TRIT_N};
  localparam logic [5:0] OP_OR    = {TRIT_Z, TRIT_P, TRIT_Z};
  localparam logic [5:0] OP_XOR   = {TRIT_Z, TRIT_P, TRIT_P};
  localparam logic [5:0] OP_ADD   = {TRIT_Z, TRIT_P, TRIT_N};
  localparam logic [5:0] OP_SUB   = {TRIT_Z, TRIT_N, TRIT_Z};
  localparam logic [5:0] OP_COMP  = {TRIT_Z, TRIT_N, TRIT_P};
  localparam logic [5:0] OP_ANDI  = {TRIT_Z, TRIT_N, TRIT_N};
  localparam logic [5:0] OP_ADDI  = {TRIT_P, TRIT_Z, TRIT_Z};
  localparam logic [5:0] OP_LT    = {TRIT_P, TRIT_Z, TRIT_P};
  localparam logic [5:0] OP_EQ    = {TRIT_P, TRIT_Z, TRIT_N};
  localparam logic [5:0] OP_LOAD  = {TRIT_P, TRIT_P, TRIT_Z};
  localparam logic [5:0] OP_STORE = {TRIT_P, TRIT_P, TRIT_P};
  localparam logic [5:0] OP_JMP   = {TRIT_P, TRIT_P, TRIT_N};
  localparam logic [5:0] OP_BEQ   = {TRIT_P, TRIT_N, TRIT_Z};
  localparam logic [5:0] OP_LUI   = {TRIT_P, TRIT_N, TRIT_P};

  function automatic logic op_is_alu(input logic [5:0] op);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_XOR,
      OP_ADD, OP_SUB, OP_COMP, OP_ANDI,
      OP_ADDI, OP_LT, OP_EQ: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

  function automatic logic op_defined(input logic [5:0] op);
    case (op)
      OP_NOP, OP_LOAD, OP_STORE,
      OP_JMP, OP_BEQ, OP_LUI: return 1'b1;
      default:                return op_is_alu(op);
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// Combinational field split, class flags and
// immediate extension for one instruction word.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_DEF,
  parameter int OPCODE_SIZE    = OPCODE_SIZE_DEF,
  parameter int REG_ADDR_SIZE  = REG_ADDR_SIZE_DEF,
  parameter int SMALL_IMM_SIZE = SMALL_IMM_SIZE_DEF
) (
  input  logic [2*WORD_SIZE-1:0]      instr_i,
  output logic [2*OPCODE_SIZE-1:0]    opcode_o,
  output logic [2*REG_ADDR_SIZE-1:0]  reg_dest_o,
  output logic [2*REG_ADDR_SIZE-1:0]  reg_src_o,
  output logic [2*SMALL_IMM_SIZE-1:0] small_imm_o,
  output logic [2*(REG_ADDR_SIZE+SMALL_IMM_SIZE)-1:0] big_imm_o,
  output logic [2*WORD_SIZE-1:0]      imm_ext_o,
  output logic                        is_alu_o,
  output logic                        is_illegal_o
);

  localparam int OW = 2*OPCODE_SIZE;
  localparam int CW = (OW > 6) ? OW : 6;

  logic          bad_trit;
  logic [CW-1:0] opx;
  logic          op_fits;

  assign {opcode_o, reg_dest_o,
          reg_src_o, small_imm_o} = instr_i;

  assign big_imm_o = {reg_src_o, small_imm_o};
  // Balanced ternary is symmetric: zero trits extend any sign
  assign imm_ext_o = (2*WORD_SIZE)'(big_imm_o);

  always_comb begin
    bad_trit = 1'b0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (instr_i[2*i +: 2] == TRIT_X) bad_trit = 1'b1;
    end
  end

  assign opx     = CW'(opcode_o);
  assign op_fits = (opx >> 6) == '0;

  assign is_illegal_o = bad_trit
                      | ~(op_fits & op_defined(opx[5:0]));
  assign is_alu_o     = op_fits & op_is_alu(opx[5:0])
                      & ~is_illegal_o;

endmodule

// File: rtl/decode_stage.sv
// Ternary decode stage: decodes each accepted word and
// queues the decoded record for the execute stage.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int WORD_SIZE      = WORD_SIZE_DEF,
  parameter int OPCODE_SIZE    = OPCODE_SIZE_DEF,
  parameter int REG_ADDR_SIZE  = REG_ADDR_SIZE_DEF,
  parameter int SMALL_IMM_SIZE = SMALL_IMM_SIZE_DEF,
  parameter int DEPTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*WORD_SIZE-1:0]      instruction,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*OPCODE_SIZE-1:0]    opcode,
  output logic [2*REG_ADDR_SIZE-1:0]  reg_dest,
  output logic [2*REG_ADDR_SIZE-1:0]  reg_src,
  output logic [2*SMALL_IMM_SIZE-1:0] small_imm,
  output logic [2*(REG_ADDR_SIZE+SMALL_IMM_SIZE)-1:0] big_imm,
  output logic [2*WORD_SIZE-1:0]      imm_ext,
  output logic                        is_alu_operation,
  output logic                        is_illegal,
  output logic [15:0]                 illegal_count
);

  localparam int W2    = 2*WORD_SIZE;
  localparam int OW    = 2*OPCODE_SIZE;
  localparam int RW    = 2*REG_ADDR_SIZE;
  localparam int SW    = 2*SMALL_IMM_SIZE;
  localparam int BW    = RW + SW;
  localparam int REC_W = W2 + BW + W2 + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  if (WORD_SIZE != OPCODE_SIZE + 2*REG_ADDR_SIZE
                   + SMALL_IMM_SIZE) begin : g_bad_word
    $error("decode_stage: WORD_SIZE does not match fields");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth
    $error("decode_stage: DEPTH must be a power of two >= 2");
  end

  logic [OW-1:0] d_op;
  logic [RW-1:0] d_rd;
  logic [RW-1:0] d_rs;
  logic [SW-1:0] d_si;
  logic [BW-1:0] d_big;
  logic [W2-1:0] d_ext;
  logic          d_alu;
  logic          d_ill;

  decode_fields #(
    .WORD_SIZE      (WORD_SIZE),
    .OPCODE_SIZE    (OPCODE_SIZE),
    .REG_ADDR_SIZE  (REG_ADDR_SIZE),
    .SMALL_IMM_SIZE (SMALL_IMM_SIZE)
  ) u_fields (
    .instr_i      (instruction),
    .opcode_o     (d_op),
    .reg_dest_o   (d_rd),
    .reg_src_o    (d_rs),
    .small_imm_o  (d_si),
    .big_imm_o    (d_big),
    .imm_ext_o    (d_ext),
    .is_alu_o     (d_alu),
    .is_illegal_o (d_ill)
  );

  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic [15:0]   ill_cnt_q, ill_cnt_d;
  logic          push, pop;

  assign rec_in = {d_op, d_rd, d_rs, d_si,
                   d_big, d_ext, d_alu, d_ill};

  assign out_valid = cnt_q != '0;
  assign in_ready  = rdy_q;
  assign push = in_valid & rdy_q & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (push && d_ill && ill_cnt_q != 16'hFFFF)
        ill_cnt_d = ill_cnt_q + 16'd1;
    end
    // Ready is registered, so it stays low through reset
    rdy_d = cnt_d != CW'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_in;
  end

  assign rec_out = out_valid ? mem_q[rd_ptr_q] : '0;

  assign {opcode, reg_dest, reg_src, small_imm,
          big_imm, imm_ext,
          is_alu_operation, is_illegal} = rec_out;

  assign illegal_count = ill_cnt_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter WORD_SIZE, default 9: instruction width in trits; every trit is 2 bits, so buses are 2*N bits wide.
REQ-002 Parameter OPCODE_SIZE, default 3: opcode field width in trits.
REQ-003 Parameter REG_ADDR_SIZE, default 2: register address field width in trits.
REQ-004 Parameter SMALL_IMM_SIZE, default 2: small immediate width in trits; WORD_SIZE SHALL equal OPCODE_SIZE+2*REG_ADDR_SIZE+SMALL_IMM_SIZE, with an elaboration-time error otherwise.
REQ-005 Parameter DEPTH, default 4: output queue entries, a power of two, at least 2.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 flush  in  1  synchronous queue discard.
REQ-009 in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-010 instruction  in  2*WORD_SIZE  fields {opcode, reg_dest, reg_src, small_imm}, MSB first.
REQ-011 out_valid / out_ready  out / in  1 / 1  decoded-record handshake.
REQ-012 opcode, reg_dest, reg_src, small_imm  out  field widths x2  raw fields of the head entry.
REQ-013 big_imm  out  2*(REG_ADDR_SIZE+SMALL_IMM_SIZE)  {reg_src, small_imm}.
REQ-014 imm_ext  out  2*WORD_SIZE  big_imm extended to WORD_SIZE trits.
REQ-015 is_alu_operation, is_illegal  out  1 each  class flags of the head entry.
REQ-016 illegal_count  out  16  saturating count of illegal instructions accepted.

Function
REQ-017 Trit encoding: 2'b00=0, 2'b01=+1, 2'b10=-1, 2'b11 invalid.
REQ-018 imm_ext SHALL prepend zero trits (2'b00) to big_imm; balanced ternary needs no sign replication.
REQ-019 is_alu_operation SHALL be 1 iff the opcode is one of `NOT, `AND, `OR, `XOR, `ADD, `SUB, `COMP, `ANDI, `ADDI, `LT or `EQ.
REQ-020 is_illegal SHALL be 1 iff any instruction trit equals 2'b11, or the opcode matches no opcode defined in the shared package.
REQ-021 An instruction is accepted on a clock edge where in_valid and in_ready are both 1 and flush is 0; decode occurs before enqueue, and the queue stores decoded records.
REQ-022 in_ready SHALL be 1 iff the queue is not full; a pop on the same edge does not permit a push at full.
REQ-023 Latency: an instruction accepted into an empty queue SHALL appear with out_valid=1 on the following cycle.
REQ-024 A record is retired on an edge where out_valid and out_ready are both 1; a simultaneous push and pop when partially full leaves the count unchanged.
REQ-025 While out_valid=1 and out_ready=0, all output fields SHALL hold stable.
REQ-026 Records leave in acceptance order; read and write pointers wrap modulo DEPTH.
REQ-027 flush=1 SHALL empty the queue at the edge, drop that cycle's input and pop, and leave illegal_count unchanged.
REQ-028 illegal_count SHALL increment on each accepted illegal instruction and saturate at 16'hFFFF.
REQ-029 Output fields SHALL be all zeros whenever out_valid=0.

Reset
REQ-030 When rst_n=0: queue empty, out_valid=0, in_ready=0, illegal_count=0, all fields zero, applied asynchronously.
REQ-031 in_ready SHALL rise on the first clock edge after rst_n deasserts; a reset asserted mid-transfer discards all queued records.

Structure
REQ-032 Opcode macros, trit encodings and the default field sizes belong in the shared parameters header.
REQ-033 Field split, class flags and immediate extension SHALL be a combinational sub-module named decode_fields; the queue and counters live in decode_stage.

Verification
REQ-034 Accept an `ADD instruction with trits reg_dest=(+1,0), reg_src=(0,-1), small_imm=(+1,+1), out_ready=1 -> next cycle out_valid=1, is_alu_operation=1, is_illegal=0, big_imm=(0,-1,+1,+1), imm_ext=(0,0,0,0,0,0,-1,+1,+1).
REQ-035 Hold out_ready=0 and push 5 instructions with DEPTH=4 -> in_ready=0 after 4 accepts; the 5th is held; drain yields 4 records in order.
REQ-036 Send an instruction containing one 2'b11 trit -> is_illegal=1, is_alu_operation=0, illegal_count=1.
REQ-037 Fill 3 entries, then assert flush together with in_valid=1 -> next cycle out_valid=0, queue empty, in_ready=1, input dropped.
REQ-038 Assert rst_n=0 asynchronously between edges with 2 entries queued -> out_valid drops immediately; after release, in_ready rises on the next edge.
REQ-039 Preload illegal_count to 16'hFFFE via forced state and send 3 illegal instructions -> count holds at 16'hFFFF.
